mcb_port_model: RTL and testbench

- Synthesizable responder for one Spartan-6 MCB user port (command, write and read FIFO interface), backed by on-chip block RAM instead of DDR.
- Lets the DDR test controller and other port-0 initiators run in simulation and board bring-up without the external memory or PHY.
- Sits where the MCB wrapper sits; every initiator-facing signal carries MCB port semantics.

---
 rtl/mcb_port_model_if.sv | 56 +++++
 rtl/mcb_port_model.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_mcb_port_model.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcb_port_model_if.sv
// ---------------------------------------------------------------------------
// mcb_port_model_if
// Bundles the signals of one Spartan-6 MCB user port: the command FIFO, the
// write-data FIFO and the read-data FIFO, plus the calibration-done status.
//
// Modports:
//   master - initiator side (drives cmd_*, wr_en/wr_mask/wr_data, rd_en)
//   slave  - memory side (mcb_port_model; drives status, counts, rd_data)
// ---------------------------------------------------------------------------
interface mcb_port_model_if;
    logic        calib_done;

    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_empty;
    logic        cmd_full;

    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        wr_empty;
    logic [6:0]  wr_count;
    logic        wr_underrun;
    logic        wr_error;

    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_full;
    logic        rd_empty;
    logic [6:0]  rd_count;
    logic        rd_overflow;
    logic        rd_error;

    modport master (
        input  calib_done,
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        input  cmd_empty, cmd_full,
        output wr_en, wr_mask, wr_data,
        input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
        output rd_en,
        input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
    );

    modport slave (
        output calib_done,
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        output cmd_empty, cmd_full,
        input  wr_en, wr_mask, wr_data,
        output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
        input  rd_en,
        output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
    );
endinterface

// File: rtl/mcb_port_model.sv
// ---------------------------------------------------------------------------
// mcb_port_model
// Block-RAM backed stand-in for one Spartan-6 MCB user port. Accepts
// commands, write data and read pops with MCB port semantics and executes
// them in order against an on-chip 32-bit-wide RAM.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (clears FIFOs, engine, flags;
//          RAM contents survive)
//   mcb  - MCB user-port bundle (slave modport of mcb_port_model_if)
//
// Also contains mcb_port_model_fifo, the first-word-fall-through FIFO used
// for the command, write and read queues.
// ---------------------------------------------------------------------------

// First-word-fall-through FIFO over an inferred RAM with registered read.
// o_head is a register that always holds the word at the read pointer; it is
// refilled each cycle from the location the read pointer will point at next,
// with a bypass when that same location is being written this cycle.
module mcb_port_model_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [AW:0]      o_count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [AW-1:0] w_rd_ptr_next;

    assign w_full        = (r_count == (AW+1)'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_push_ok     = i_push && !w_full;
    assign w_pop_ok      = i_pop && !w_empty;
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok)
            mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_ptr_next;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_ok && (r_wr_ptr == w_rd_ptr_next))
                r_head <= i_data;
            else
                r_head <= mem[w_rd_ptr_next];
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;
endmodule

module mcb_port_model #(
    parameter int ADDR_WIDTH     = 10,
    parameter int CALIB_CYCLES   = 64,
    parameter int READ_LATENCY   = 8,
    parameter int REFRESH_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    mcb_port_model_if.slave    mcb
);
    localparam int CAL_W    = $clog2(CALIB_CYCLES + 1);
    localparam int WAIT_MAX = (READ_LATENCY > REFRESH_CYCLES) ? READ_LATENCY : REFRESH_CYCLES;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int CMD_W    = 3 + 6 + ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_WAIT,
        S_READ,
        S_REFRESH
    } state_t;

    // ---------------- calibration ----------------
    logic [CAL_W-1:0] r_calib_cnt;
    logic             r_calib_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_calib_cnt  <= '0;
            r_calib_done <= 1'b0;
        end else if (!r_calib_done) begin
            r_calib_cnt  <= r_calib_cnt + CAL_W'(1);
            r_calib_done <= (r_calib_cnt == CAL_W'(CALIB_CYCLES - 1));
        end
    end

    // ---------------- FIFOs ----------------
    // Initiator strobes are ignored until calibration completes.
    logic w_cmd_push;
    logic w_wr_push;
    logic w_rd_pop;
    assign w_cmd_push = mcb.cmd_en && r_calib_done;
    assign w_wr_push  = mcb.wr_en  && r_calib_done;
    assign w_rd_pop   = mcb.rd_en  && r_calib_done;

    logic [CMD_W-1:0] w_cmd_head;
    logic [2:0]       w_cmd_count;
    logic [35:0]      w_wf_head;
    logic [6:0]       w_wf_count;
    logic [31:0]      w_rf_head;
    logic [6:0]       w_rf_count;
    logic [31:0]      w_ram_rdata;
    logic             r_ram_rd_valid;
    logic             w_cmd_pop;
    logic             w_wf_pop;

    mcb_port_model_fifo #(.WIDTH(CMD_W), .DEPTH(4)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cmd_push),
        .i_data  ({mcb.cmd_instr, mcb.cmd_bl, mcb.cmd_byte_addr[ADDR_WIDTH+1:2]}),
        .i_pop   (w_cmd_pop),
        .o_head  (w_cmd_head),
        .o_count (w_cmd_count)
    );

    mcb_port_model_fifo #(.WIDTH(36), .DEPTH(64)) u_wr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wr_push),
        .i_data  ({mcb.wr_mask, mcb.wr_data}),
        .i_pop   (w_wf_pop),
        .o_head  (w_wf_head),
        .o_count (w_wf_count)
    );

    mcb_port_model_fifo #(.WIDTH(32), .DEPTH(64)) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_ram_rd_valid),
        .i_data  (w_ram_rdata),
        .i_pop   (w_rd_pop),
        .o_head  (w_rf_head),
        .o_count (w_rf_count)
    );

    logic w_cmd_empty;
    logic w_wf_empty;
    logic w_wf_full;
    logic w_rf_empty;
    logic w_rf_full;
    assign w_cmd_empty = (w_cmd_count == 3'd0);
    assign w_wf_empty  = (w_wf_count == 7'd0);
    assign w_wf_full   = (w_wf_count == 7'd64);
    assign w_rf_empty  = (w_rf_count == 7'd0);
    assign w_rf_full   = (w_rf_count == 7'd64);

    logic [2:0]            w_cmd_instr;
    logic [5:0]            w_cmd_bl;
    logic [ADDR_WIDTH-1:0] w_cmd_addr;
    assign w_cmd_instr = w_cmd_head[CMD_W-1 -: 3];
    assign w_cmd_bl    = w_cmd_head[ADDR_WIDTH +: 6];
    assign w_cmd_addr  = w_cmd_head[ADDR_WIDTH-1:0];

    // ---------------- engine FSM ----------------
    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [6:0]            r_beats;
    logic [CNT_W-1:0]      r_cnt;

    logic w_beat;
    logic w_cnt_dec;
    logic w_ram_we;
    logic w_ram_re;
    logic w_underrun;

    always_comb begin
        w_state_next = r_state;
        w_cmd_pop    = 1'b0;
        w_wf_pop     = 1'b0;
        w_beat       = 1'b0;
        w_cnt_dec    = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_re     = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_cmd_empty) begin
                    w_cmd_pop = 1'b1;
                    // Reserved encodings 101/110/111 are consumed and dropped.
                    if (w_cmd_instr[2])
                        w_state_next = (w_cmd_instr[1:0] == 2'b00) ? S_REFRESH : S_IDLE;
                    else if (w_cmd_instr[0])
                        w_state_next = S_READ_WAIT;
                    else
                        w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_beat   = 1'b1;
                w_wf_pop = 1'b1;
                if (w_wf_empty)
                    w_underrun = 1'b1;
                else
                    w_ram_we = 1'b1;
                if (r_beats == 7'd1)
                    w_state_next = S_IDLE;
            end
            S_READ_WAIT: begin
                w_cnt_dec = 1'b1;
                if (r_cnt <= CNT_W'(1))
                    w_state_next = S_READ;
            end
            S_READ: begin
                w_beat   = 1'b1;
                w_ram_re = 1'b1;
                if (r_beats == 7'd1)
                    w_state_next = S_IDLE;
            end
            S_REFRESH: begin
                w_cnt_dec = 1'b1;
                if (r_cnt <= CNT_W'(1))
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_beats        <= '0;
            r_cnt          <= '0;
            r_ram_rd_valid <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            // RAM read data is registered, so the read FIFO push trails the
            // READ beat by one cycle.
            r_ram_rd_valid <= w_ram_re;
            if (w_cmd_pop) begin
                r_addr  <= w_cmd_addr;
                r_beats <= {1'b0, w_cmd_bl} + 7'd1;
                r_cnt   <= w_cmd_instr[0] ? CNT_W'(READ_LATENCY) : CNT_W'(REFRESH_CYCLES);
            end else begin
                if (w_beat) begin
                    r_addr  <= r_addr + ADDR_WIDTH'(1);
                    r_beats <= r_beats - 7'd1;
                end
                if (w_cnt_dec)
                    r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // ---------------- backing RAM, one array per byte lane ----------------
    // Splitting by byte lets the write mask map onto per-lane write enables
    // instead of a read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [2**ADDR_WIDTH];
            logic [7:0] r_lane_q;
            always_ff @(posedge clk) begin
                if (w_ram_we && !w_wf_head[32+gi])
                    lane_mem[r_addr] <= w_wf_head[8*gi +: 8];
                r_lane_q <= lane_mem[r_addr];
            end
            assign w_ram_rdata[8*gi +: 8] = r_lane_q;
        end
    endgenerate

    // ---------------- sticky error flags ----------------
    logic r_wr_underrun;
    logic r_wr_error;
    logic r_rd_overflow;
    logic r_rd_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_underrun <= 1'b0;
            r_wr_error    <= 1'b0;
            r_rd_overflow <= 1'b0;
            r_rd_error    <= 1'b0;
        end else begin
            if (w_wr_push && w_wf_full)
                r_wr_error <= 1'b1;
            if (w_underrun) begin
                r_wr_underrun <= 1'b1;
                r_wr_error    <= 1'b1;
            end
            if (w_rd_pop && w_rf_empty)
                r_rd_error <= 1'b1;
            if (r_ram_rd_valid && w_rf_full) begin
                r_rd_overflow <= 1'b1;
                r_rd_error    <= 1'b1;
            end
        end
    end

    // ---------------- port outputs ----------------
    assign mcb.calib_done  = r_calib_done;
    assign mcb.cmd_empty   = w_cmd_empty;
    assign mcb.cmd_full    = (w_cmd_count == 3'd4);
    assign mcb.wr_full     = w_wf_full;
    assign mcb.wr_empty    = w_wf_empty;
    assign mcb.wr_count    = w_wf_count;
    assign mcb.wr_underrun = r_wr_underrun;
    assign mcb.wr_error    = r_wr_error;
    assign mcb.rd_data     = w_rf_head;
    assign mcb.rd_full     = w_rf_full;
    assign mcb.rd_empty    = w_rf_empty;
    assign mcb.rd_count    = w_rf_count;
    assign mcb.rd_overflow = r_rd_overflow;
    assign mcb.rd_error    = r_rd_error;
endmodule

// File: tb/tb_mcb_port_model.sv
// ---------------------------------------------------------------------------
// tb_mcb_port_model
// Directed self-checking bench for mcb_port_model (default parameters:
// ADDR_WIDTH=10, CALIB_CYCLES=64, READ_LATENCY=8, REFRESH_CYCLES=16).
// A table of masked single-word writes is applied in a loop; calibration,
// long bursts, underrun, overflow, address wrap and command-FIFO full are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_mcb_port_model;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mcb_port_model_if bus();

    mcb_port_model #(
        .ADDR_WIDTH     (10),
        .CALIB_CYCLES   (64),
        .READ_LATENCY   (8),
        .REFRESH_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mcb (bus)
    );

    localparam logic [2:0] I_WR  = 3'b000;
    localparam logic [2:0] I_RD  = 3'b001;
    localparam logic [2:0] I_REF = 3'b100;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic [3:0]  mask;
        logic [31:0] exp_w;
    } mask_vec_t;

    mask_vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        bus.cmd_en        = 1'b1;
        bus.cmd_instr     = instr;
        bus.cmd_bl        = bl;
        bus.cmd_byte_addr = addr;
        tick();
        bus.cmd_en = 1'b0;
        $display("cmd instr=%03b bl=%0d byte_addr=0x%08h", instr, bl, addr);
    endtask

    task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        bus.wr_mask = m;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pop_rd(output logic [31:0] d);
        int waited = 0;
        while (bus.rd_empty && waited < 300) begin
            tick();
            waited++;
        end
        if (bus.rd_empty) begin
            n_total++;
            $display("FAIL pop_timeout: rd_empty still 1 after %0d cycles, want 0", waited);
            d = '0;
        end else begin
            d = bus.rd_data;
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    // Apply reset, check the reset state, then check calibration timing.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (3) tick();
        check({tag, "_rst_calib"},     32'(bus.calib_done), 32'd0);
        check({tag, "_rst_cmd_empty"}, 32'(bus.cmd_empty),  32'd1);
        check({tag, "_rst_cmd_full"},  32'(bus.cmd_full),   32'd0);
        check({tag, "_rst_wr_empty"},  32'(bus.wr_empty),   32'd1);
        check({tag, "_rst_wr_count"},  32'(bus.wr_count),   32'd0);
        check({tag, "_rst_rd_empty"},  32'(bus.rd_empty),   32'd1);
        check({tag, "_rst_rd_count"},  32'(bus.rd_count),   32'd0);
        check({tag, "_rst_rd_data"},   bus.rd_data,         32'd0);
        check({tag, "_rst_sticky"},
              32'({bus.wr_underrun, bus.wr_error, bus.rd_overflow, bus.rd_error}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 63; i++) begin
            // Strobes during calibration must be ignored.
            if (i == 10) begin
                bus.cmd_en = 1'b1;
                bus.wr_en  = 1'b1;
                bus.rd_en  = 1'b1;
            end
            tick();
            bus.cmd_en = 1'b0;
            bus.wr_en  = 1'b0;
            bus.rd_en  = 1'b0;
        end
        check({tag, "_calib_at_63"},      32'(bus.calib_done), 32'd0);
        check({tag, "_precal_wr_count"},  32'(bus.wr_count),   32'd0);
        check({tag, "_precal_cmd_empty"}, 32'(bus.cmd_empty),  32'd1);
        check({tag, "_precal_rd_error"},  32'(bus.rd_error),   32'd0);
        tick();
        check({tag, "_calib_at_64"},      32'(bus.calib_done), 32'd1);
    endtask

    initial begin
        logic [31:0] d;

        bus.cmd_en        = 1'b0;
        bus.cmd_instr     = '0;
        bus.cmd_bl        = '0;
        bus.cmd_byte_addr = '0;
        bus.wr_en         = 1'b0;
        bus.wr_mask       = '0;
        bus.wr_data       = '0;
        bus.rd_en         = 1'b0;

        // addr, old word, new word, mask (1 = keep old byte), expected word
        vecs[0] = '{30'h0000_0010, 32'h1122_3344, 32'hAABB_CCDD, 4'b0101, 32'hAA22_CC44};
        vecs[1] = '{30'h0000_0020, 32'hDEAD_BEEF, 32'h0123_4567, 4'b0000, 32'h0123_4567};
        vecs[2] = '{30'h0000_0024, 32'hCAFE_F00D, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D};
        vecs[3] = '{30'h0000_0028, 32'h5555_5555, 32'hAAAA_AAAA, 4'b1010, 32'h55AA_55AA};
        vecs[4] = '{30'h0000_002F, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'b0001, 32'hF0F0_F00F};
        vecs[5] = '{30'h1000_0030, 32'h1234_5678, 32'h9ABC_DEF0, 4'b1100, 32'h1234_DEF0};

        // ---- reset and calibration ----
        do_reset("r1");

        // ---- 64-word write burst, then 64-word read burst ----
        for (int i = 0; i < 64; i++) push_wr(32'(i), 4'b0000);
        check("burst_wr_count", 32'(bus.wr_count), 32'd64);
        check("burst_wr_full",  32'(bus.wr_full),  32'd1);
        push_cmd(I_WR, 6'd63, 30'h0);
        push_cmd(I_RD, 6'd63, 30'h0);
        wait_cycles(170);
        check("burst_rd_count",  32'(bus.rd_count), 32'd64);
        check("burst_rd_full",   32'(bus.rd_full),  32'd1);
        check("burst_wr_empty",  32'(bus.wr_empty), 32'd1);
        check("burst_cmd_empty", 32'(bus.cmd_empty), 32'd1);
        for (int i = 0; i < 64; i++) begin
            pop_rd(d);
            check($sformatf("burst_data[%0d]", i), d, 32'(i));
        end
        check("burst_rd_empty", 32'(bus.rd_empty), 32'd1);
        check("burst_sticky",
              32'({bus.wr_underrun, bus.wr_error, bus.rd_overflow, bus.rd_error}), 32'd0);

        // ---- masked single-word writes, table driven ----
        for (int v = 0; v < 6; v++) begin
            push_wr(vecs[v].old_w, 4'b0000);
            push_wr(vecs[v].new_w, vecs[v].mask);
            push_cmd(I_WR, 6'd0, vecs[v].addr);
            push_cmd(I_WR, 6'd0, vecs[v].addr);
            push_cmd(I_RD, 6'd0, vecs[v].addr);
            pop_rd(d);
            check($sformatf("mask_vec[%0d]", v), d, vecs[v].exp_w);
        end

        // ---- rd_en with read FIFO empty ----
        wait_cycles(5);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("rd_empty_pop_error",    32'(bus.rd_error),    32'd1);
        check("rd_empty_pop_overflow", 32'(bus.rd_overflow), 32'd0);
        check("rd_empty_pop_count",    32'(bus.rd_count),    32'd0);

        // ---- write underrun ----
        for (int i = 0; i < 4; i++) push_wr(32'h5000_0000 + 32'(i), 4'b0000);
        push_cmd(I_WR, 6'd3, 30'h100);
        wait_cycles(20);
        check("full_burst_no_underrun", 32'(bus.wr_underrun), 32'd0);
        push_wr(32'h6000_0000, 4'b0000);
        push_wr(32'h6000_0001, 4'b0000);
        push_cmd(I_WR, 6'd3, 30'h100);
        wait_cycles(20);
        check("underrun_flag",  32'(bus.wr_underrun), 32'd1);
        check("underrun_error", 32'(bus.wr_error),    32'd1);
        push_cmd(I_RD, 6'd3, 30'h100);
        pop_rd(d); check("underrun_word0", d, 32'h6000_0000);
        pop_rd(d); check("underrun_word1", d, 32'h6000_0001);
        pop_rd(d); check("underrun_word2", d, 32'h5000_0002);
        pop_rd(d); check("underrun_word3", d, 32'h5000_0003);

        // ---- second reset: FIFOs and flags clear, RAM keeps its data ----
        push_wr(32'h7777_0000, 4'b0000);
        push_wr(32'h7777_0001, 4'b0000);
        check("pre_reset_wr_count", 32'(bus.wr_count), 32'd2);
        do_reset("r2");
        push_cmd(I_RD, 6'd0, 30'h10);
        pop_rd(d);
        check("ram_kept_over_reset", d, 32'hAA22_CC44);

        // ---- read FIFO overflow ----
        push_cmd(I_RD, 6'd63, 30'h0);
        wait_cycles(100);
        check("ovf_fill_count",    32'(bus.rd_count),    32'd64);
        check("ovf_fill_no_flag",  32'(bus.rd_overflow), 32'd0);
        push_cmd(I_RD, 6'd1, 30'h0);
        wait_cycles(30);
        check("ovf_flag",          32'(bus.rd_overflow), 32'd1);
        check("ovf_error",         32'(bus.rd_error),    32'd1);
        check("ovf_count_held",    32'(bus.rd_count),    32'd64);
        check("ovf_wr_error_clear", 32'(bus.wr_error),   32'd0);
        pop_rd(d);
        check("ovf_head_word0", d, 32'd0);
        for (int i = 1; i < 64; i++) pop_rd(d);
        check("ovf_drained", 32'(bus.rd_empty), 32'd1);

        // ---- burst wrapping past the top of RAM ----
        for (int i = 0; i < 4; i++) push_wr(32'hC0DE_0000 + 32'(i), 4'b0000);
        push_cmd(I_WR, 6'd3, 30'hFF8);
        push_cmd(I_RD, 6'd3, 30'hFF8);
        for (int i = 0; i < 4; i++) begin
            pop_rd(d);
            check($sformatf("wrap_rd_ff8[%0d]", i), d, 32'hC0DE_0000 + 32'(i));
        end
        push_cmd(I_RD, 6'd2, 30'h0);
        pop_rd(d); check("wrap_word0", d, 32'hC0DE_0002);
        pop_rd(d); check("wrap_word1", d, 32'hC0DE_0003);
        pop_rd(d); check("wrap_word2_untouched", d, 32'd2);

        // ---- command FIFO full while the engine is stalled in REFRESH ----
        push_cmd(I_REF, 6'd0, 30'h0);
        wait_cycles(3);
        check("refresh_cmd_taken", 32'(bus.cmd_empty), 32'd1);
        for (int k = 0; k < 5; k++) begin
            push_cmd(I_RD, 6'd0, 30'h0);
            if (k == 3) check("cmd_full_after_4", 32'(bus.cmd_full), 32'd1);
        end
        check("cmd_full_after_5", 32'(bus.cmd_full), 32'd1);
        wait_cycles(100);
        check("cmd_drop_rd_count", 32'(bus.rd_count),  32'd4);
        check("cmd_drop_empty",    32'(bus.cmd_empty), 32'd1);
        for (int i = 0; i < 4; i++) pop_rd(d);
        check("cmd_drop_final_empty", 32'(bus.rd_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
